vliw_scoreboard: RTL and testbench

Parametrised scoreboard and forwarding controller for the VLIW datapath, generalising the fixed two-slot forwarding and hazard-detection pair to SLOTS issue slots and a DEPTH-stage back end. It sits beside the ID/EX pipeline register. It tracks the destination of every in-flight slot, produces registered per-operand bypass selects aligned with EX, and raises a load-use stall that freezes PC and IF/ID and injects a bubble.

---
 rtl/vliw_sb_pkg.sv | 22 ++
 rtl/sb_operand_match.sv | 39 +++
 rtl/vliw_scoreboard.sv | 111 +++++++++++
 tb/tb_vliw_scoreboard.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_sb_pkg.sv
// Shared types and helpers for the VLIW scoreboard: register-id layout,
// per-slot in-flight entry record and the bypass select encoding.
package vliw_sb_pkg;

  localparam int SB_REG_W    = 4;
  localparam int SB_FILE_BIT = SB_REG_W - 1;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] dst;
    logic                we;
    logic                is_load;
  } sb_entry_t;

  // Select 0 means register file; the oldest tracked stage retires into a
  // write-first register file, so it never needs a bypass.
  function automatic int enc_sel(input int k, input int s, input int slots, input int depth);
    if (k >= depth - 1) return 0;
    return 1 + k * slots + s;
  endfunction

endpackage

// File: rtl/sb_operand_match.sv
// Priority matcher for one source operand against every in-flight entry:
// youngest stage wins, then the highest slot within that stage.
module sb_operand_match
  import vliw_sb_pkg::*;
#(
  parameter int SLOTS = 2,
  parameter int DEPTH = 3,
  parameter int K_W   = 2,
  parameter int S_W   = 1
) (
  input  sb_entry_t [DEPTH-1:0][SLOTS-1:0] stages,
  input  logic [SB_REG_W-1:0]              src,
  input  logic                             used,
  output logic                             hit,
  output logic [K_W-1:0]                   k,
  output logic [S_W-1:0]                   s,
  output logic                             is_load
);

  // Scan oldest to youngest, lowest to highest slot, so the last match wins.
  always_comb begin
    hit     = 1'b0;
    k       = '0;
    s       = '0;
    is_load = 1'b0;
    for (int kk = DEPTH - 1; kk >= 0; kk--) begin
      for (int ss = 0; ss < SLOTS; ss++) begin
        if (used && stages[kk][ss].valid && stages[kk][ss].we &&
            (stages[kk][ss].dst == src)) begin
          hit     = 1'b1;
          k       = K_W'(kk);
          s       = S_W'(ss);
          is_load = stages[kk][ss].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/vliw_scoreboard.sv
// Scoreboard and forwarding controller beside ID/EX. Optional performance
// counters are enabled by defining VLIW_SB_PERF_CNT_EN.
module vliw_scoreboard
  import vliw_sb_pkg::*;
#(
  parameter int SLOTS      = 2,
  parameter int REG_W      = SB_REG_W,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2((DEPTH - 1) * SLOTS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [SLOTS*2*REG_W-1:0]   id_src,
  input  logic [SLOTS*2-1:0]         id_src_used,
  input  logic [SLOTS*REG_W-1:0]     id_dst,
  input  logic [SLOTS-1:0]           id_dst_we,
  input  logic [SLOTS-1:0]           id_is_load,
  input  logic                       flush,
  output logic                       stall,
  output logic                       issue,
  output logic [SLOTS*2*SEL_W-1:0]   fwd_sel
`ifdef VLIW_SB_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                issue_count
`endif
);

  localparam int NOPS = SLOTS * 2;
  localparam int K_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int S_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  sb_entry_t [DEPTH-1:0][SLOTS-1:0] stages;
  sb_entry_t [SLOTS-1:0]            issue_entry;

  logic [NOPS-1:0]            hit;
  logic [NOPS-1:0]            hit_load;
  logic [NOPS-1:0][K_W-1:0]   hit_k;
  logic [NOPS-1:0][S_W-1:0]   hit_s;
  logic [NOPS-1:0][SEL_W-1:0] next_sel;
  logic                       hazard;

  for (genvar op = 0; op < NOPS; op++) begin : g_op
    sb_operand_match #(
      .SLOTS (SLOTS),
      .DEPTH (DEPTH),
      .K_W   (K_W),
      .S_W   (S_W)
    ) u_match (
      .stages  (stages),
      .src     (id_src[op*REG_W +: REG_W]),
      .used    (id_src_used[op]),
      .hit     (hit[op]),
      .k       (hit_k[op]),
      .s       (hit_s[op]),
      .is_load (hit_load[op])
    );
  end

  // A producer in stage k sits in stage k+1 once the consumer reaches EX, so
  // a load is only forwardable if k+1 has reached LOAD_STAGE.
  always_comb begin
    hazard   = 1'b0;
    next_sel = '0;
    for (int op = 0; op < NOPS; op++) begin
      if (hit[op]) begin
        next_sel[op] = SEL_W'(enc_sel(int'(hit_k[op]), int'(hit_s[op]), SLOTS, DEPTH));
        if (hit_load[op] && (int'(hit_k[op]) + 1 < LOAD_STAGE)) hazard = 1'b1;
      end
    end
  end

  assign stall = id_valid & hazard & ~flush;
  assign issue = id_valid & ~hazard & ~flush;

  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      issue_entry[s].valid   = 1'b1;
      issue_entry[s].dst     = id_dst[s*REG_W +: REG_W];
      issue_entry[s].we      = id_dst_we[s];
      issue_entry[s].is_load = id_is_load[s];
    end
  end

  // Flush needs no special case here: it forces issue low, so stage 0 takes a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      stages  <= '0;
      fwd_sel <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) stages[k] <= stages[k-1];
      stages[0] <= issue ? issue_entry : '0;
      fwd_sel   <= issue ? next_sel : '0;
    end
  end

`ifdef VLIW_SB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if (stall && id_valid && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (issue && (issue_count != '1)) issue_count <= issue_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vliw_scoreboard.sv
// Self-checking bench for vliw_scoreboard: directed scenarios with literal
// expectations plus randomized traffic against an issue-history model.
module tb_vliw_scoreboard;

  localparam int SLOTS      = 2;
  localparam int REG_W      = 4;
  localparam int DEPTH      = 3;
  localparam int LOAD_STAGE = 2;
  localparam int SEL_W      = 3;
  localparam int NOPS       = SLOTS * 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     id_valid;
  logic [NOPS*REG_W-1:0]    id_src;
  logic [NOPS-1:0]          id_src_used;
  logic [SLOTS*REG_W-1:0]   id_dst;
  logic [SLOTS-1:0]         id_dst_we;
  logic [SLOTS-1:0]         id_is_load;
  logic                     flush;
  logic                     stall;
  logic                     issue;
  logic [NOPS*SEL_W-1:0]    fwd_sel;
`ifdef VLIW_SB_PERF_CNT_EN
  logic [31:0]              stall_cycles;
  logic [31:0]              issue_count;
`endif

  int errors = 0;
  int checks = 0;

  vliw_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_dst       (id_dst),
    .id_dst_we    (id_dst_we),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .fwd_sel      (fwd_sel)
`ifdef VLIW_SB_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .issue_count  (issue_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every issued bundle is remembered with the cycle it issued in; its
  // stage is simply its age, and bubbles/flushes are just cycles with no entry.
  typedef struct {
    int                     cyc;
    logic [SLOTS-1:0]       we;
    logic [SLOTS-1:0]       ld;
    logic [SLOTS*REG_W-1:0] dst;
  } bundle_t;

  bundle_t                   hist[$];
  int                        cyc = 0;
  logic [NOPS*SEL_W-1:0]     exp_fwd = '0;
  logic [NOPS-1:0][SEL_W-1:0] m_sel;
  logic                      m_haz, m_found, e_stall, e_issue;
  int                        m_age;
  int                        exp_stall_cnt = 0;
  int                        exp_issue_cnt = 0;

  always @(negedge clk) begin
    checkOutput("model_fwd_sel", 32'(fwd_sel), 32'(exp_fwd));
`ifdef VLIW_SB_PERF_CNT_EN
    checkOutput("model_stall_cycles", stall_cycles, 32'(exp_stall_cnt));
    checkOutput("model_issue_count", issue_count, 32'(exp_issue_cnt));
`endif
    m_haz = 1'b0;
    m_sel = '0;
    for (int op = 0; op < NOPS; op++) begin
      m_found = 1'b0;
      if (id_src_used[op]) begin
        for (int b = hist.size() - 1; b >= 0; b--) begin
          m_age = cyc - hist[b].cyc - 1;
          for (int s = SLOTS - 1; s >= 0; s--) begin
            if (!m_found && m_age <= DEPTH - 1 && hist[b].we[s] &&
                hist[b].dst[s*REG_W +: REG_W] == id_src[op*REG_W +: REG_W]) begin
              m_found   = 1'b1;
              m_sel[op] = (m_age == DEPTH - 1) ? '0 : SEL_W'(1 + m_age * SLOTS + s);
              if (hist[b].ld[s] && (m_age + 1 < LOAD_STAGE)) m_haz = 1'b1;
            end
          end
        end
      end
    end
    e_stall = id_valid && m_haz && !flush;
    e_issue = id_valid && !m_haz && !flush;
    checkOutput("model_stall", 32'(stall), 32'(e_stall));
    checkOutput("model_issue", 32'(issue), 32'(e_issue));
    if (reset) begin
      hist.delete();
      exp_fwd       = '0;
      exp_stall_cnt = 0;
      exp_issue_cnt = 0;
    end else begin
      if (e_issue) hist.push_back('{cyc: cyc, we: id_dst_we, ld: id_is_load, dst: id_dst});
      exp_fwd = e_issue ? m_sel : '0;
      if (e_stall) exp_stall_cnt++;
      if (e_issue) exp_issue_cnt++;
    end
    cyc++;
    while (hist.size() > 0 && (cyc - hist[0].cyc - 1) > DEPTH - 1) void'(hist.pop_front());
  end

  function automatic logic [15:0] mk_src(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c, input logic [3:0] d);
    return {d, c, b, a};
  endfunction

  task automatic applyStimulus(input logic v, input logic [15:0] src, input logic [3:0] used,
                               input logic [7:0] dst, input logic [1:0] we,
                               input logic [1:0] ld, input logic fl);
    id_valid    = v;
    id_src      = src;
    id_src_used = used;
    id_dst      = dst;
    id_dst_we   = we;
    id_is_load  = ld;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'hEEEE, 4'h0, 8'h00, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic issueCheck(input string tag);
    @(negedge clk);
    checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
    checkOutput({tag, "_issue"}, 32'(issue), 32'd1);
    tick();
  endtask

  task automatic exCheck(input string tag, input logic [11:0] exp);
    idle();
    @(negedge clk);
    checkOutput({tag, "_fwd"}, 32'(fwd_sel), 32'(exp));
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_issue", 32'(issue), 32'd0);
    checkOutput("rst_fwd", 32'(fwd_sel), 32'd0);
    tick();

    // Independent bundles
    begin
      logic [7:0] dsts [4];
      dsts = '{8'h10, 8'h54, 8'h98, 8'hBA};
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1'b1, mk_src(4'h6, 4'h7, 4'hE, 4'hF), 4'hF, dsts[i], 2'b11, 2'b00, 1'b0);
        @(negedge clk);
        checkOutput("indep_stall", 32'(stall), 32'd0);
        checkOutput("indep_issue", 32'(issue), 32'd1);
        if (i > 0) checkOutput("indep_fwd", 32'(fwd_sel), 32'd0);
        tick();
      end
      exCheck("indep_last", 12'h000);
      drain();
    end

    // ALU -> ALU back to back, then with one bundle between
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'h30, 2'b11, 2'b00, 1'b0);
    issueCheck("alu_prod");
    applyStimulus(1'b1, mk_src(4'h3, 4'hE, 4'hE, 4'hE), 4'b0001, 8'h00, 2'b00, 2'b00, 1'b0);
    issueCheck("alu_cons");
    exCheck("alu_b2b", 12'h002);
    drain();
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'h30, 2'b11, 2'b00, 1'b0);
    issueCheck("alu_prod2");
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'h00, 2'b00, 2'b00, 1'b0);
    issueCheck("alu_mid");
    applyStimulus(1'b1, mk_src(4'h3, 4'hE, 4'hE, 4'hE), 4'b0001, 8'h00, 2'b00, 2'b00, 1'b0);
    issueCheck("alu_cons2");
    exCheck("alu_gap", 12'h004);
    drain();

    // Load-use: one stall cycle, then forward from MEM
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'h0D, 2'b01, 2'b01, 1'b0);
    issueCheck("ld_prod");
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hD), 4'b1000, 8'h00, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("ld_stall1", 32'(stall), 32'd1);
    checkOutput("ld_issue1", 32'(issue), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("ld_stall2", 32'(stall), 32'd0);
    checkOutput("ld_issue2", 32'(issue), 32'd1);
    checkOutput("ld_bubble_fwd", 32'(fwd_sel), 32'd0);
    tick();
    exCheck("ld_use", 12'h600);
    drain();

    // Priority among duplicate writers
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'h22, 2'b11, 2'b00, 1'b0);
    issueCheck("pri_a");
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'h42, 2'b11, 2'b00, 1'b0);
    issueCheck("pri_b");
    applyStimulus(1'b1, mk_src(4'h2, 4'hE, 4'hE, 4'hE), 4'b0001, 8'h00, 2'b00, 2'b00, 1'b0);
    issueCheck("pri_c");
    exCheck("pri_young", 12'h001);
    drain();
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'h22, 2'b11, 2'b00, 1'b0);
    issueCheck("pri_a2");
    applyStimulus(1'b1, mk_src(4'h2, 4'hE, 4'hE, 4'hE), 4'b0001, 8'h00, 2'b00, 2'b00, 1'b0);
    issueCheck("pri_c2");
    exCheck("pri_slot", 12'h002);
    drain();

    // Flush overrides a pending load-use stall; flushed bundle leaves no trace
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'h0D, 2'b01, 2'b01, 1'b0);
    issueCheck("fl_prod");
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hD), 4'b1000, 8'h01, 2'b01, 2'b00, 1'b0);
    #1;
    checkOutput("fl_pre_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("fl_stall", 32'(stall), 32'd0);
    checkOutput("fl_issue", 32'(issue), 32'd0);
    tick();
    applyStimulus(1'b1, mk_src(4'h1, 4'hE, 4'hE, 4'hE), 4'b0001, 8'h00, 2'b00, 2'b00, 1'b0);
    issueCheck("fl_next");
    exCheck("fl_next", 12'h000);
    drain();

    // Reset during a stall with all stages occupied
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'h76, 2'b11, 2'b00, 1'b0);
    issueCheck("rs_x1");
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'hF6, 2'b11, 2'b00, 1'b0);
    issueCheck("rs_x2");
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hE), 4'h0, 8'h0D, 2'b01, 2'b01, 1'b0);
    issueCheck("rs_x3");
    applyStimulus(1'b1, mk_src(4'hE, 4'hE, 4'hE, 4'hD), 4'b1000, 8'h00, 2'b00, 2'b00, 1'b0);
    #1;
    checkOutput("rs_pre_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rs_stall", 32'(stall), 32'd0);
    checkOutput("rs_issue", 32'(issue), 32'd1);
    checkOutput("rs_fwd", 32'(fwd_sel), 32'd0);
`ifdef VLIW_SB_PERF_CNT_EN
    checkOutput("rs_stall_cycles", stall_cycles, 32'd0);
    checkOutput("rs_issue_count", issue_count, 32'd0);
`endif
    tick();
    exCheck("rs_after", 12'h000);
    drain();

    // Randomized traffic over a small register pool to force collisions
    for (int n = 0; n < 600; n++) begin
      logic [15:0] src;
      logic [7:0]  dst;
      for (int i = 0; i < 4; i++) src[i*4 +: 4] = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 2))};
      for (int i = 0; i < 2; i++) dst[i*4 +: 4] = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 2))};
      applyStimulus(1'($urandom_range(0, 9) < 8), src, 4'($urandom), dst, 2'($urandom),
                    2'($urandom), 1'($urandom_range(0, 19) == 0));
      reset = 1'($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    drain();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
